// File: rtl/wptr_full_ctrl.sv
// ---------------------------------------------------------------------------
// wptr_full_ctrl
//
// Write-side pointer and full-flag controller for an asynchronous FIFO.
// It keeps the binary write pointer, publishes its Gray form to the read
// domain, and derives full / almost-full / occupancy from the Gray read
// pointer that has already been synchronized into wclk.
//
// Optional feature: define WPTR_AFULL_EN to build the almost-full comparator.
// Without it walmost_full is tied to 0 and AFULL_GAP has no effect.
//
// Parameters
//   ptr_width  address width; FIFO depth is 2**ptr_width (ptr_width >= 2)
//   AFULL_GAP  free-slot count at or below which walmost_full asserts
//              (1..DEPTH-1)
//
// Ports
//   wclk          in   write-domain clock, rising edge
//   w_rst_n       in   synchronous active-low reset
//   winc          in   write request from producer
//   rptr_sync     in   Gray read pointer, synchronized into wclk
//   wovf_clr      in   clears the sticky overflow flag
//   wen           out  write strobe to FIFO memory
//   waddr         out  memory write address
//   wptr          out  registered Gray write pointer toward read domain
//   wfull         out  FIFO full (registered)
//   walmost_full  out  FIFO almost full (registered)
//   wlevel        out  write-side occupancy 0..DEPTH (registered)
//   woverflow     out  sticky: write attempted while full
//
// Handshake: winc acts as "valid" and ~wfull as "ready"; a word is taken
// exactly on a cycle where both are high (wen). A request while full is
// dropped, leaves the pointer untouched, and sets woverflow.
// ---------------------------------------------------------------------------
module wptr_full_ctrl #(
  parameter int ptr_width = 8,
  parameter int AFULL_GAP = 2
) (
  input  logic                 wclk,
  input  logic                 w_rst_n,
  input  logic                 winc,
  input  logic [ptr_width:0]   rptr_sync,
  input  logic                 wovf_clr,
  output logic                 wen,
  output logic [ptr_width-1:0] waddr,
  output logic [ptr_width:0]   wptr,
  output logic                 wfull,
  output logic                 walmost_full,
  output logic [ptr_width:0]   wlevel,
  output logic                 woverflow
);

  logic [ptr_width:0] wbin;
  logic [ptr_width:0] wbin_next;
  logic [ptr_width:0] wgray_next;
  logic [ptr_width:0] rbin;
  logic [ptr_width:0] rptr_full_pat;
  logic [ptr_width:0] wlevel_next;
  logic               wfull_next;
  logic               wovf_next;

  assign waddr = wbin[ptr_width-1:0];

  // Write acceptance and next pointer. wbin is one bit wider than the
  // address so full and empty stay distinguishable; it wraps naturally.
  always_comb begin
    wen        = winc & ~wfull;
    wbin_next  = wbin + {{ptr_width{1'b0}}, wen};
    wgray_next = wbin_next ^ (wbin_next >> 1);
  end

  // Gray -> binary for the read pointer: each binary bit is the XOR of all
  // Gray bits at or above it, accumulated from the MSB down.
  always_comb begin
    logic acc;
    acc  = 1'b0;
    rbin = '0;
    for (int i = ptr_width; i >= 0; i--) begin
      acc     = acc ^ rptr_sync[i];
      rbin[i] = acc;
    end
  end

  // Full when the next write pointer is exactly DEPTH ahead of the read
  // pointer. In Gray code a distance of DEPTH means the top two bits are
  // inverted and the rest equal. Because the comparison uses wgray_next,
  // wfull rises on the same edge that accepts the last free word. It can
  // only fall once a newer rptr_sync has arrived, so release is late
  // (synchronizer delay + this register) but never early.
  always_comb begin
    rptr_full_pat = {~rptr_sync[ptr_width:ptr_width-1], rptr_sync[ptr_width-2:0]};
    wfull_next    = (wgray_next == rptr_full_pat);
    wlevel_next   = wbin_next - rbin;
  end

  // Sticky overflow: a new overflow in the same cycle as a clear wins, so
  // a clear can never hide an event it did not observe.
  always_comb begin
    wovf_next = woverflow;
    if (winc & wfull) begin
      wovf_next = 1'b1;
    end else if (wovf_clr) begin
      wovf_next = 1'b0;
    end
  end

  always_ff @(posedge wclk) begin
    if (!w_rst_n) begin
      wbin      <= '0;
      wptr      <= '0;
      wfull     <= 1'b0;
      wlevel    <= '0;
      woverflow <= 1'b0;
    end else begin
      wbin      <= wbin_next;
      wptr      <= wgray_next;
      wfull     <= wfull_next;
      wlevel    <= wlevel_next;
      woverflow <= wovf_next;
    end
  end

`ifdef WPTR_AFULL_EN
  localparam int DEPTH = 2 ** ptr_width;
  localparam logic [ptr_width:0] AFULL_THRESH = (ptr_width + 1)'(DEPTH - AFULL_GAP);

  // Same occupancy value that feeds wlevel, so both flags agree on an edge.
  always_ff @(posedge wclk) begin
    if (!w_rst_n) begin
      walmost_full <= 1'b0;
    end else begin
      walmost_full <= (wlevel_next >= AFULL_THRESH);
    end
  end
`else
  assign walmost_full = 1'b0;
`endif

endmodule

// File: doc/wptr_full_ctrl.md
WPTR_FULL_CTRL -- requirements
Module: wptr_full_ctrl

Interface
REQ-001 SHALL have parameter ptr_width, default 8, address width; FIFO depth DEPTH = 2**ptr_width.
REQ-002 SHALL have parameter AFULL_GAP, default 2, free-slot count at or below which walmost_full asserts; legal range 1..DEPTH-1.
REQ-003 SHALL have port wclk  input  1  write-domain clock, all state on rising edge.
REQ-004 SHALL have port w_rst_n  input  1  reset, synchronous, active-low; clock wclk.
REQ-005 SHALL have port winc  input  1  write request from producer.
REQ-006 SHALL have port rptr_sync  input  ptr_width+1  Gray read pointer, already two-flop synchronized into wclk.
REQ-007 SHALL have port wovf_clr  input  1  clears sticky overflow flag.
REQ-008 SHALL have port wen  output  1  write strobe to FIFO memory.
REQ-009 SHALL have port waddr  output  ptr_width  memory write address.
REQ-010 SHALL have port wptr  output  ptr_width+1  registered Gray write pointer toward read domain.
REQ-011 SHALL have port wfull  output  1  FIFO full, registered.
REQ-012 SHALL have port walmost_full  output  1  FIFO almost full, registered.
REQ-013 SHALL have port wlevel  output  ptr_width+1  write-side occupancy, 0..DEPTH, registered.
REQ-014 SHALL have port woverflow  output  1  sticky: write attempted while full.

Function
REQ-015 SHALL hold internal binary pointer wbin (ptr_width+1 bits); waddr = wbin[ptr_width-1:0], combinational from register.
REQ-016 SHALL drive wen = winc & ~wfull combinationally; a write with wfull=1 is dropped, pointer unchanged.
REQ-017 SHALL compute wbin_next = wbin + wen, modulo 2**(ptr_width+1), natural wrap with no special case.
REQ-018 SHALL register wptr <= wbin_next ^ (wbin_next >> 1) on the same edge as wbin <= wbin_next.
REQ-019 SHALL register wfull <= (wgray_next == {~rptr_sync[ptr_width:ptr_width-1], rptr_sync[ptr_width-2:0]}), so wfull rises on the edge that accepts the DEPTH-th unread word (zero-cycle lag).
REQ-020 SHALL deassert wfull only after a changed rptr_sync arrives; release latency = 2 wclk sync + 1 register, conservative, never early.
REQ-021 SHALL convert rptr_sync to binary rbin by prefix XOR from MSB, and register wlevel <= wbin_next - rbin, modulo 2**(ptr_width+1).
REQ-022 SHALL set woverflow when winc & wfull; clear it when wovf_clr; set SHALL win over clear in the same cycle.
REQ-023 SHALL tolerate rptr_sync changing every cycle; only Gray-adjacent input steps are assumed (guaranteed by synchronizer).

Reset
REQ-024 SHALL, when w_rst_n=0 at a wclk edge, force wbin, wptr, wlevel to 0 and wfull, walmost_full, woverflow to 0, regardless of winc.
REQ-025 SHALL allow reset mid-operation; in-flight write in the reset cycle is discarded; read domain must be reset in the same window (system rule).
REQ-026 SHALL, during reset, output wen = winc & ~wfull using the registered wfull, which is 0 after the first reset edge.

Configuration
REQ-027 SHALL compile the almost-full logic only when macro WPTR_AFULL_EN is defined: walmost_full <= (wbin_next - rbin) >= DEPTH - AFULL_GAP.
REQ-028 SHALL, without WPTR_AFULL_EN, tie walmost_full to constant 0, with no comparator and AFULL_GAP unused; all other behaviour identical.

Verification (ptr_width=3, DEPTH=8, AFULL_GAP=2, WPTR_AFULL_EN defined)
REQ-029 SHALL cover: reset, rptr_sync=0, 8 back-to-back winc -> waddr 0..7, wptr Gray 0,1,3,2,6,7,5,4,C; wfull=1 after 8th edge; wlevel=8; walmost_full=1 after 6th write.
REQ-030 SHALL cover: full, then a 9th winc -> wen=0, wptr stays 4'hC, woverflow=1 and held; wovf_clr+winc same cycle -> woverflow stays 1.
REQ-031 SHALL cover: full, then rptr_sync steps 0->1 -> wfull=0 next edge, wlevel=7, walmost_full stays 1; one write -> full again, wlevel=8.
REQ-032 SHALL cover wrap: 20 writes interleaved with matching rptr_sync updates -> wbin passes 15->0, wptr 4'h8->4'h0, no false wfull, wlevel matches model.
REQ-033 SHALL cover: w_rst_n=0 for 1 cycle at wlevel=5 with winc=1 -> all outputs 0 next edge, waddr=0.
REQ-034 SHALL cover a rebuild without WPTR_AFULL_EN -> walmost_full constant 0 through the REQ-029 sequence, other outputs unchanged.
